// File: rtl/demux4_stream.sv
`default_nettype none
// ============================================================================
// Module   : demux4_stream
// Purpose  : 1-to-4 streaming demultiplexer with one registered output slot
//            per channel and independent valid/ready handshakes.
//            Optional delivery counters enabled by macro DEMUX4_COUNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module demux4_stream #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_sel,
    output logic             in_ready,
    output logic             out0_valid,
    output logic             out1_valid,
    output logic             out2_valid,
    output logic             out3_valid,
    output logic [WIDTH-1:0] out0,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [WIDTH-1:0] out3,
    input  logic             out0_ready,
    input  logic             out1_ready,
    input  logic             out2_ready,
    input  logic             out3_ready
`ifdef DEMUX4_COUNT_EN
    ,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1,
    output logic [CNT_W-1:0] cnt2,
    output logic [CNT_W-1:0] cnt3,
    input  logic             cnt_clr
`endif
);

    logic [3:0]       r_full;
    logic [WIDTH-1:0] r_buf [4];

    logic [3:0] w_rdy;
    logic [3:0] w_take;
    logic [3:0] w_put_vec;
    logic       w_put;

    assign w_rdy  = {out3_ready, out2_ready, out1_ready, out0_ready};
    assign w_take = r_full & w_rdy;

    // Only the selected channel's occupancy and ready gate the input, so a
    // stalled channel never blocks traffic bound elsewhere.
    assign in_ready  = ~rst & (~r_full[in_sel] | w_rdy[in_sel]);
    assign w_put     = in_valid & in_ready;
    assign w_put_vec = w_put ? (4'b0001 << in_sel) : 4'b0000;

    generate
        for (genvar i = 0; i < 4; i++) begin : g_ch
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_full[i] <= 1'b0;
                    r_buf[i]  <= '0;
                end else if (w_put_vec[i]) begin
                    // A put refills the slot even while it drains this cycle.
                    r_full[i] <= 1'b1;
                    r_buf[i]  <= in_data;
                end else if (w_take[i]) begin
                    r_full[i] <= 1'b0;
                end
            end
        end
    endgenerate

    assign out0_valid = r_full[0];
    assign out1_valid = r_full[1];
    assign out2_valid = r_full[2];
    assign out3_valid = r_full[3];
    assign out0       = r_buf[0];
    assign out1       = r_buf[1];
    assign out2       = r_buf[2];
    assign out3       = r_buf[3];

`ifdef DEMUX4_COUNT_EN
    logic [CNT_W-1:0] r_cnt [4];

    generate
        for (genvar i = 0; i < 4; i++) begin : g_cnt
            always_ff @(posedge clk) begin
                if (rst || cnt_clr) begin
                    r_cnt[i] <= '0;
                end else if (w_take[i]) begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    endgenerate

    assign cnt0 = r_cnt[0];
    assign cnt1 = r_cnt[1];
    assign cnt2 = r_cnt[2];
    assign cnt3 = r_cnt[3];
`endif

endmodule
`default_nettype wire

// File: tb/tb_demux4_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_demux4_stream
// Purpose  : Self-checking bench for demux4_stream against a per-channel
//            queue model of accepted-but-undelivered words.
// Revision : 1.0 - initial release
// ============================================================================
module tb_demux4_stream;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic [1:0]       in_sel;
    logic             in_ready;
    logic             out0_valid, out1_valid, out2_valid, out3_valid;
    logic [WIDTH-1:0] out0, out1, out2, out3;
    logic [3:0]       rdy;
    logic             cnt_clr;
    logic [CNT_W-1:0] cnt0, cnt1, cnt2, cnt3;

    always #5 clk = ~clk;

    demux4_stream #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_ready   (in_ready),
        .out0_valid (out0_valid),
        .out1_valid (out1_valid),
        .out2_valid (out2_valid),
        .out3_valid (out3_valid),
        .out0       (out0),
        .out1       (out1),
        .out2       (out2),
        .out3       (out3),
        .out0_ready (rdy[0]),
        .out1_ready (rdy[1]),
        .out2_ready (rdy[2]),
        .out3_ready (rdy[3])
`ifdef DEMUX4_COUNT_EN
        ,
        .cnt0       (cnt0),
        .cnt1       (cnt1),
        .cnt2       (cnt2),
        .cnt3       (cnt3),
        .cnt_clr    (cnt_clr)
`endif
    );

`ifndef DEMUX4_COUNT_EN
    assign cnt0 = '0;
    assign cnt1 = '0;
    assign cnt2 = '0;
    assign cnt3 = '0;
`endif

    logic [3:0]       vld;
    logic [WIDTH-1:0] od [4];
    logic [CNT_W-1:0] oc [4];
    assign vld   = {out3_valid, out2_valid, out1_valid, out0_valid};
    assign od[0] = out0;
    assign od[1] = out1;
    assign od[2] = out2;
    assign od[3] = out3;
    assign oc[0] = cnt0;
    assign oc[1] = cnt1;
    assign oc[2] = cnt2;
    assign oc[3] = cnt3;

    // Reference: words accepted per channel, in order, not yet taken.
    logic [WIDTH-1:0] q [4][$];
    int               mcnt [4];

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: compare DUT to the model mid-cycle, then advance the model.
    task automatic step();
        logic       exp_rdy;
        logic [3:0] take;
        logic       put;
        @(negedge clk);
        exp_rdy = !rst && !(q[in_sel].size() != 0 && !rdy[in_sel]);
        chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
        for (int n = 0; n < 4; n++) begin
            chk($sformatf("valid%0d", n), {31'd0, vld[n]}, {31'd0, q[n].size() != 0});
            if (q[n].size() != 0)
                chk($sformatf("data%0d", n), {24'd0, od[n]}, {24'd0, q[n][0]});
`ifdef DEMUX4_COUNT_EN
            chk($sformatf("cnt%0d", n), {28'd0, oc[n]}, mcnt[n]);
`endif
            take[n] = (q[n].size() != 0) && rdy[n];
        end
        put = in_valid && exp_rdy;
        @(posedge clk);
        if (rst) begin
            for (int n = 0; n < 4; n++) begin
                q[n].delete();
                mcnt[n] = 0;
            end
        end else begin
            for (int n = 0; n < 4; n++) begin
                if (take[n]) begin
                    void'(q[n].pop_front());
                    mcnt[n] = cnt_clr ? 0 : (mcnt[n] + 1) % (1 << CNT_W);
                end else if (cnt_clr) begin
                    mcnt[n] = 0;
                end
            end
            if (put) q[in_sel].push_back(in_data);
        end
        #1;
    endtask

    task automatic send(input logic [1:0] s, input logic [WIDTH-1:0] d);
        in_valid = 1'b1;
        in_sel   = s;
        in_data  = d;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b1; in_sel = 2'd0; in_data = 8'hFF;
        rdy = 4'hF; cnt_clr = 1'b0;
        for (int n = 0; n < 4; n++) mcnt[n] = 0;

        // Reset holds off the input even with in_valid high.
        step(); step();
        rst = 1'b0; in_valid = 1'b0;
        for (int n = 0; n < 4; n++) begin
            chk($sformatf("rst_valid%0d", n), {31'd0, vld[n]}, 32'd0);
            chk($sformatf("rst_data%0d", n), {24'd0, od[n]}, 32'd0);
            chk($sformatf("rst_cnt%0d", n), {28'd0, oc[n]}, 32'd0);
        end

        // Streaming across all four channels.
        for (int n = 0; n < 4; n++) begin
            send(n[1:0], 8'hA0 + n[7:0]);
            step();
            chk("stream_vld", {31'd0, vld[n]}, 32'd1);
            chk("stream_dat", {24'd0, od[n]}, 32'hA0 + n);
        end
        in_valid = 1'b0;
        step(); step();

        // Head-of-line stall on channel 1.
        rdy[1] = 1'b0;
        send(2'd1, 8'h11); step();
        send(2'd1, 8'h12); step(); step();
        chk("hold_out1", {24'd0, out1}, 32'h11);
        chk("hold_rdy", {31'd0, in_ready}, 32'd0);
        rdy[1] = 1'b1; step();
        chk("pass_out1", {24'd0, out1}, 32'h12);
        send(2'd3, 8'h33); step();
        chk("out3_33", {24'd0, out3}, 32'h33);
        in_valid = 1'b0; step(); step();

        // Refill-while-draining on channel 2.
        rdy[2] = 1'b0;
        send(2'd2, 8'h44); step();
        rdy[2] = 1'b1;
        send(2'd2, 8'h5A); step();
        chk("pt_vld2", {31'd0, out2_valid}, 32'd1);
        chk("pt_dat2", {24'd0, out2}, 32'h5A);
        in_valid = 1'b0; step();

        // Reset discards a buffered word.
        rdy[0] = 1'b0;
        send(2'd0, 8'h77); step();
        in_valid = 1'b0; rst = 1'b1; step();
        rst = 1'b0;
        chk("rst_mid_vld0", {31'd0, out0_valid}, 32'd0);
        chk("rst_mid_dat0", {24'd0, out0}, 32'd0);
        rdy[0] = 1'b1; step();

`ifdef DEMUX4_COUNT_EN
        // Counter wrap and clear-over-increment on channel 3.
        cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
        rdy = 4'hF;
        for (int k = 0; k < 17; k++) begin
            send(2'd3, k[7:0]); step();
        end
        in_valid = 1'b0; step();
        chk("cnt3_wrap", {28'd0, cnt3}, 32'd1);
        send(2'd3, 8'hC3); step();
        in_valid = 1'b0; cnt_clr = 1'b1; step();
        cnt_clr = 1'b0;
        chk("cnt3_clr", {28'd0, cnt3}, 32'd0);
`endif

        // Randomized traffic with backpressure, occasional reset and clear.
        for (int k = 0; k < 3000; k++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_sel   = 2'($urandom_range(0, 3));
            in_data  = 8'($urandom);
            for (int n = 0; n < 4; n++) rdy[n] = ($urandom_range(0, 2) != 0);
            rst      = ($urandom_range(0, 199) == 0);
            cnt_clr  = ($urandom_range(0, 63) == 0);
            step();
        end
        rst = 1'b0; in_valid = 1'b0; cnt_clr = 1'b0; rdy = 4'hF;
        step(); step();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire
